sync_fifo_prog: RTL and testbench

Parametrised single-clock FIFO, next generation of the team's fixed-size FIFO. It adds configurable data width and depth, run-time programmable almost-full/almost-empty thresholds, an occupancy count output, a synchronous flush, and a choice between standard registered read and first-word-fall-through (FWFT) read. It is the buffering block for datapaths between producer and consumer agents that share one clock.

---
 rtl/fifo_pkg.sv | 19 +
 rtl/sync_fifo_prog_if.sv | 36 +++
 rtl/fifo_mem.sv | 23 ++
 rtl/sync_fifo_prog.sv | 106 ++++++++++
 tb/tb_sync_fifo_prog.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types, defaults and sizing helper for sync_fifo_prog
package fifo_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 8;

    typedef struct packed {
        logic full;
        logic empty;
        logic almostfull;
        logic almostempty;
    } fifo_status_t;

    // Count must represent 0..depth inclusive, hence depth+1 states.
    function automatic int clog2_cnt(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_prog_if.sv
// rtl/sync_fifo_prog_if.sv - producer/consumer/status bundle for sync_fifo_prog
interface sync_fifo_prog_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = clog2_cnt(DEFAULT_DEPTH)
);
    logic             flush;
    logic             wr_en;
    logic [WIDTH-1:0] din;
    logic             rd_en;
    logic [WIDTH-1:0] dout;
    logic             rd_valid;
    logic             wr_ack;
    logic             overflow;
    logic             underflow;
    logic             full;
    logic             empty;
    logic             almostfull;
    logic             almostempty;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] af_thresh;
    logic [CNT_W-1:0] ae_thresh;

    modport master (
        output flush, wr_en, din, rd_en, af_thresh, ae_thresh,
        input  dout, rd_valid, wr_ack, overflow, underflow,
               full, empty, almostfull, almostempty, count
    );

    modport slave (
        input  flush, wr_en, din, rd_en, af_thresh, ae_thresh,
        output dout, rd_valid, wr_ack, overflow, underflow,
               full, empty, almostfull, almostempty, count
    );
endinterface

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - WIDTH x DEPTH array, synchronous write, asynchronous read
module fifo_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_prog.sv
// rtl/sync_fifo_prog.sv - single-clock FIFO with programmable thresholds, flush and FWFT option
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int FWFT  = 0,
    parameter int CNT_W = clog2_cnt(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    sync_fifo_prog_if.slave    bus
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] dout_q;
    logic             rd_valid_q;
    logic             wr_ack_q;
    logic             overflow_q;
    logic             underflow_q;
    logic             wr_ok;
    logic             rd_ok;
    fifo_status_t     status;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        status.full        = (count_q == CNT_W'(DEPTH));
        status.empty       = (count_q == '0);
        status.almostfull  = (bus.af_thresh != '0) && (count_q >= bus.af_thresh) && !status.full;
        status.almostempty = (count_q <= bus.ae_thresh) && !status.empty;
        // A full FIFO still takes a write when the head is popped in the same cycle.
        wr_ok = bus.wr_en && (!status.full || bus.rd_en);
        rd_ok = bus.rd_en && !status.empty;
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok && !bus.flush),
        .waddr (wr_ptr),
        .wdata (bus.din),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            dout_q      <= '0;
            rd_valid_q  <= 1'b0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            dout_q      <= '0;
            rd_valid_q  <= 1'b0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (rd_ok) begin
                rd_ptr <= next_ptr(rd_ptr);
                dout_q <= rd_data;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            rd_valid_q  <= rd_ok;
            wr_ack_q    <= wr_ok;
            overflow_q  <= bus.wr_en && !wr_ok;
            underflow_q <= bus.rd_en && !rd_ok;
        end
    end

    assign bus.dout        = (FWFT != 0) ? (status.empty ? '0 : rd_data) : dout_q;
    assign bus.rd_valid    = (FWFT != 0) ? !status.empty : rd_valid_q;
    assign bus.wr_ack      = wr_ack_q;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;
    assign bus.full        = status.full;
    assign bus.empty       = status.empty;
    assign bus.almostfull  = status.almostfull;
    assign bus.almostempty = status.almostempty;
    assign bus.count       = count_q;
endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb/tb_sync_fifo_prog.sv - directed vector bench for standard (DEPTH=8) and FWFT (DEPTH=5) instances
module tb_sync_fifo_prog;
    import fifo_pkg::*;

    localparam int CNT_S = clog2_cnt(8);
    localparam int CNT_F = clog2_cnt(5);

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    sync_fifo_prog_if #(.WIDTH(16), .CNT_W(CNT_S)) bus_s ();
    sync_fifo_prog_if #(.WIDTH(16), .CNT_W(CNT_F)) bus_f ();

    sync_fifo_prog #(.WIDTH(16), .DEPTH(8), .FWFT(0)) dut_std (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    sync_fifo_prog #(.WIDTH(16), .DEPTH(5), .FWFT(1)) dut_fwft (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_f)
    );

    typedef struct {
        logic        wr;
        logic        rd;
        logic        fl;
        logic [15:0] din;
        int          cnt;
        logic        ack;
        logic        ovf;
        logic        udf;
        logic        rv;
        logic [15:0] dout;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic wr, input logic rd, input logic fl, input logic [15:0] din,
                                input int cnt, input logic ack, input logic ovf, input logic udf,
                                input logic rv, input logic [15:0] dout);
        vec_t v;
        v.wr = wr; v.rd = rd; v.fl = fl; v.din = din; v.cnt = cnt;
        v.ack = ack; v.ovf = ovf; v.udf = udf; v.rv = rv; v.dout = dout;
        tbl.push_back(v);
    endfunction

    task automatic step_s(input logic wr, input logic rd, input logic fl, input logic [15:0] din);
        bus_s.wr_en = wr; bus_s.rd_en = rd; bus_s.flush = fl; bus_s.din = din;
        @(posedge clk);
        #1;
        bus_s.wr_en = 1'b0; bus_s.rd_en = 1'b0; bus_s.flush = 1'b0;
    endtask

    task automatic step_f(input logic wr, input logic rd, input logic [15:0] din);
        bus_f.wr_en = wr; bus_f.rd_en = rd; bus_f.din = din;
        @(posedge clk);
        #1;
        bus_f.wr_en = 1'b0; bus_f.rd_en = 1'b0;
    endtask

    // Thresholds fixed at af=7, ae=2 for the DEPTH=8 instance.
    task automatic chk_std(input string tag, input vec_t v);
        chk({tag, " count"},  32'(bus_s.count), 32'(v.cnt));
        chk({tag, " wr_ack"}, 32'(bus_s.wr_ack), 32'(v.ack));
        chk({tag, " ovf"},    32'(bus_s.overflow), 32'(v.ovf));
        chk({tag, " udf"},    32'(bus_s.underflow), 32'(v.udf));
        chk({tag, " rv"},     32'(bus_s.rd_valid), 32'(v.rv));
        chk({tag, " dout"},   32'(bus_s.dout), 32'(v.dout));
        chk({tag, " full"},   32'(bus_s.full), 32'(v.cnt == 8));
        chk({tag, " empty"},  32'(bus_s.empty), 32'(v.cnt == 0));
        chk({tag, " af"},     32'(bus_s.almostfull), 32'(v.cnt == 7));
        chk({tag, " ae"},     32'(bus_s.almostempty), 32'(v.cnt == 1 || v.cnt == 2));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        vec_t v;
        rst_n = 1'b0;
        bus_s.flush = 1'b0; bus_s.wr_en = 1'b0; bus_s.rd_en = 1'b0; bus_s.din = '0;
        bus_s.af_thresh = 4'd7; bus_s.ae_thresh = 4'd2;
        bus_f.flush = 1'b0; bus_f.wr_en = 1'b0; bus_f.rd_en = 1'b0; bus_f.din = '0;
        bus_f.af_thresh = 3'd4; bus_f.ae_thresh = 3'd1;
        @(posedge clk); @(posedge clk); #1;
        chk("reset count", 32'(bus_s.count), 0);
        chk("reset empty", 32'(bus_s.empty), 1);
        chk("reset full", 32'(bus_s.full), 0);
        chk("reset ae", 32'(bus_s.almostempty), 0);
        chk("reset dout", 32'(bus_s.dout), 0);
        chk("reset fwft rv", 32'(bus_f.rd_valid), 0);
        rst_n = 1'b1;

        // Reset mid-operation
        for (int k = 1; k <= 3; k++) step_s(1'b1, 1'b0, 1'b0, 16'(k));
        chk("pre-rst count", 32'(bus_s.count), 3);
        rst_n = 1'b0;
        #2;
        chk("async count", 32'(bus_s.count), 0);
        chk("async empty", 32'(bus_s.empty), 1);
        chk("async full", 32'(bus_s.full), 0);
        chk("async ae", 32'(bus_s.almostempty), 0);
        chk("async wr_ack", 32'(bus_s.wr_ack), 0);
        chk("async ovf", 32'(bus_s.overflow), 0);
        chk("async udf", 32'(bus_s.underflow), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step_s(1'b1, 1'b0, 1'b0, 16'hA5A5);
        step_s(1'b0, 1'b1, 1'b0, 16'h0);
        chk("post-rst dout", 32'(bus_s.dout), 32'hA5A5);
        chk("post-rst rv", 32'(bus_s.rd_valid), 1);

        // Vector table for the standard-mode instance
        for (int k = 1; k <= 8; k++) add(1, 0, 0, 16'(k), k, 1, 0, 0, 0, 16'hA5A5);
        add(1, 0, 0, 16'd9, 8, 0, 1, 0, 0, 16'hA5A5);
        for (int j = 1; j <= 8; j++) add(0, 1, 0, 16'h0, 8 - j, 0, 0, 0, 1, 16'(j));
        add(0, 1, 0, 16'h0, 0, 0, 0, 1, 0, 16'd8);
        add(1, 1, 0, 16'h0042, 1, 1, 0, 1, 0, 16'd8);
        add(0, 1, 0, 16'h0, 0, 0, 0, 0, 1, 16'h0042);
        for (int k = 1; k <= 8; k++) add(1, 0, 0, 16'(k), k, 1, 0, 0, 0, 16'h0042);
        add(1, 1, 0, 16'h0099, 8, 1, 0, 0, 1, 16'd1);
        for (int j = 2; j <= 8; j++) add(0, 1, 0, 16'h0, 9 - j, 0, 0, 0, 1, 16'(j));
        add(0, 1, 0, 16'h0, 0, 0, 0, 0, 1, 16'h0099);
        for (int k = 1; k <= 5; k++) add(1, 0, 0, 16'(16'h50 + k), k, 1, 0, 0, 0, 16'h0099);
        add(1, 1, 1, 16'h0077, 0, 0, 0, 0, 0, 16'h0);
        add(1, 0, 0, 16'h0033, 1, 1, 0, 0, 0, 16'h0);
        add(0, 1, 0, 16'h0, 0, 0, 0, 0, 1, 16'h0033);

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            step_s(v.wr, v.rd, v.fl, v.din);
            chk_std($sformatf("vec%0d", i), v);
        end

        // FWFT, DEPTH=5: fall-through latency and pointer wrap
        step_f(1'b1, 1'b0, 16'h0011);
        chk("fwft first dout", 32'(bus_f.dout), 32'h11);
        chk("fwft first rv", 32'(bus_f.rd_valid), 1);
        chk("fwft first count", 32'(bus_f.count), 1);
        for (int i = 1; i <= 7; i++) begin
            step_f(1'b1, 1'b1, 16'(16'h20 + i));
            chk($sformatf("fwft wrap%0d dout", i), 32'(bus_f.dout), 32'(16'h20 + i));
            chk($sformatf("fwft wrap%0d count", i), 32'(bus_f.count), 1);
            chk($sformatf("fwft wrap%0d ack", i), 32'(bus_f.wr_ack), 1);
        end
        step_f(1'b0, 1'b1, 16'h0);
        chk("fwft drained rv", 32'(bus_f.rd_valid), 0);
        chk("fwft drained empty", 32'(bus_f.empty), 1);
        step_f(1'b1, 1'b1, 16'h0042);
        chk("fwft empty wr+rd count", 32'(bus_f.count), 1);
        chk("fwft empty wr+rd udf", 32'(bus_f.underflow), 1);
        chk("fwft empty wr+rd dout", 32'(bus_f.dout), 32'h42);
        for (int k = 1; k <= 4; k++) begin
            step_f(1'b1, 1'b0, 16'(16'h60 + k));
            chk($sformatf("fwft fill%0d af", k), 32'(bus_f.almostfull), 32'(k == 3));
            chk($sformatf("fwft fill%0d full", k), 32'(bus_f.full), 32'(k == 4));
        end
        step_f(1'b1, 1'b0, 16'h0065);
        chk("fwft overflow", 32'(bus_f.overflow), 1);
        chk("fwft ovf count", 32'(bus_f.count), 5);
        for (int j = 1; j <= 4; j++) begin
            step_f(1'b0, 1'b1, 16'h0);
            chk($sformatf("fwft drain%0d dout", j), 32'(bus_f.dout), 32'(16'h60 + j));
            chk($sformatf("fwft drain%0d ae", j), 32'(bus_f.almostempty), 32'(j == 4));
        end
        step_f(1'b0, 1'b1, 16'h0);
        chk("fwft final count", 32'(bus_f.count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
